gpio_bus_arbiter: RTL and testbench

GPIO_BUS_ARBITER -- requirements
Module: gpio_bus_arbiter

---
 rtl/gpio_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_gpio_bus_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter
// Lets two masters share one GPIO register block. An idle arbiter grants one
// requester. The granted master's command is latched onto the slave port, and
// the transaction ends with a one-cycle ack. It ends on slave ready, or as an
// error if the slave does not answer within TIMEOUT wait cycles.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   mN_req/we/addr/wdata        master N command (held until mN_ack)
//   mN_ack/err/rdata            master N completion pulse, timeout flag, read data
//   s_sel/we/addr/wdata         slave command, stable for the whole transaction
//   s_rdata, s_ready            slave read data and completion
//   gnt                         one-hot owner, 00 when idle
//
// state | meaning
// IDLE  | no owner, arbitrating
// BUS0  | master 0 owns the slave port
// BUS1  | master 1 owns the slave port
module gpio_bus_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_req,
    input  logic       m0_we,
    input  logic [3:0] m0_addr,
    input  logic [7:0] m0_wdata,
    input  logic       m1_req,
    input  logic       m1_we,
    input  logic [3:0] m1_addr,
    input  logic [7:0] m1_wdata,
    output logic       m0_ack,
    output logic       m0_err,
    output logic [7:0] m0_rdata,
    output logic       m1_ack,
    output logic       m1_err,
    output logic [7:0] m1_rdata,
    output logic       s_sel,
    output logic       s_we,
    output logic [3:0] s_addr,
    output logic [7:0] s_wdata,
    input  logic [7:0] s_rdata,
    input  logic       s_ready,
    output logic [1:0] gnt
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS0 = 2'd1,
        BUS1 = 2'd2
    } state_t;

    // The wait-cycle counter holds this value during the last permitted wait cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       last_gnt_q, last_gnt_d;   // 1 = m1 was served last
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       s_we_q, s_we_d;
    logic [3:0] s_addr_q, s_addr_d;
    logic [7:0] s_wdata_q, s_wdata_d;
    logic       m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic       m0_err_q, m0_err_d, m1_err_q, m1_err_d;
    logic [7:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

    logic       req0_arb, req1_arb, pick0, pick1;
    logic       owner1, timeout_hit, done;
    logic [7:0] done_rdata;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        wait_cnt_d = wait_cnt_q;
        s_we_d     = s_we_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_err_d   = 1'b0;
        m1_err_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;

        // A master still sees its req high during its own ack cycle, so mask it
        // there to avoid re-issuing the transaction that just finished.
        req0_arb = m0_req & ~m0_ack_q;
        req1_arb = m1_req & ~m1_ack_q;
        pick0    = req0_arb & (~req1_arb | last_gnt_q);
        pick1    = req1_arb & (~req0_arb | ~last_gnt_q);

        owner1      = (state_q == BUS1);
        timeout_hit = ~s_ready & (wait_cnt_q == WAIT_LAST);
        done        = (state_q != IDLE) & (s_ready | timeout_hit);
        done_rdata  = s_ready ? s_rdata : 8'hFF;

        case (state_q)
            IDLE: begin
                if (pick0) begin
                    state_d    = BUS0;
                    s_we_d     = m0_we;
                    s_addr_d   = m0_addr;
                    s_wdata_d  = m0_wdata;
                    wait_cnt_d = 8'd0;
                end else if (pick1) begin
                    state_d    = BUS1;
                    s_we_d     = m1_we;
                    s_addr_d   = m1_addr;
                    s_wdata_d  = m1_wdata;
                    wait_cnt_d = 8'd0;
                end
            end
            BUS0, BUS1: begin
                if (done) begin
                    state_d    = IDLE;
                    last_gnt_d = owner1;
                    if (owner1) begin
                        m1_ack_d   = 1'b1;
                        m1_err_d   = ~s_ready;
                        m1_rdata_d = done_rdata;
                    end else begin
                        m0_ack_d   = 1'b1;
                        m0_err_d   = ~s_ready;
                        m0_rdata_d = done_rdata;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            wait_cnt_q <= 8'd0;
            s_we_q     <= 1'b0;
            s_addr_q   <= 4'd0;
            s_wdata_q  <= 8'd0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m0_rdata_q <= 8'd0;
            m1_rdata_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            wait_cnt_q <= wait_cnt_d;
            s_we_q     <= s_we_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_err_q   <= m0_err_d;
            m1_err_q   <= m1_err_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign gnt      = {state_q == BUS1, state_q == BUS0};
    assign s_sel    = (state_q != IDLE);
    assign s_we     = s_we_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_err   = m0_err_q;
    assign m1_err   = m1_err_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
module tb_gpio_bus_arbiter;
    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [3:0] m0_addr = 4'd0, m1_addr = 4'd0;
    logic [7:0] m0_wdata = 8'd0, m1_wdata = 8'd0;
    logic       m0_ack, m0_err, m1_ack, m1_err;
    logic [7:0] m0_rdata, m1_rdata;
    logic       s_sel, s_we;
    logic [3:0] s_addr;
    logic [7:0] s_wdata;
    logic [7:0] s_rdata = 8'd0;
    logic       s_ready = 1'b0;
    logic [1:0] gnt;

    int tests_run = 0;
    int tests_failed = 0;
    int last_served = 1;   // model: which master the arbiter served last

    gpio_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready), .gnt(gnt)
    );

    always #5 clk = ~clk;

    task automatic set_master(input int m, input logic req, input logic we,
                              input logic [3:0] a, input logic [7:0] wd);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = wd;
        end else begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = wd;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0; s_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_served = 1;
    endtask

    // Drives one single-master transaction and returns what was observed.
    // The slave raises s_ready in the lat-th cycle of the bus ownership (0-based).
    // Called at a negedge with the DUT idle; returns at a negedge.
    task automatic run_txn(input int m, input logic we, input logic [3:0] a,
                           input logic [7:0] wd, input int lat, input logic [7:0] rd,
                           output int ack_at, output logic err, output logic [7:0] rdata,
                           output bit hold_ok, output bit post_ok);
        int k = 0;
        logic [1:0] own = (m == 0) ? 2'b01 : 2'b10;
        ack_at = -1; err = 1'b0; rdata = 8'd0; hold_ok = 1'b1; post_ok = 1'b1;
        set_master(m, 1'b1, we, a, wd);
        for (int cyc = 1; cyc <= 40 && ack_at < 0; cyc++) begin
            @(negedge clk);
            s_ready = 1'b0;
            s_rdata = 8'($urandom);
            if ((m == 0) ? m0_ack : m1_ack) begin
                ack_at = cyc;
                err    = (m == 0) ? m0_err : m1_err;
                rdata  = (m == 0) ? m0_rdata : m1_rdata;
                if (s_sel || gnt != 2'b00 || (m0_ack && m1_ack)) hold_ok = 1'b0;
            end else begin
                if (gnt != own || !s_sel || s_we != we || s_addr != a || s_wdata != wd)
                    hold_ok = 1'b0;
                if (m0_ack || m1_ack) hold_ok = 1'b0;
                if (k == lat) begin
                    s_ready = 1'b1;
                    s_rdata = rd;
                end
                k++;
                // scramble the command; the slave side must not follow it
                set_master(m, 1'b1, 1'($urandom), 4'($urandom), 8'($urandom));
            end
        end
        set_master(m, 1'b0, 1'b0, 4'd0, 8'd0);
        s_ready = 1'b0;
        @(negedge clk);
        if (m0_ack || m1_ack || m0_err || m1_err || s_sel ||
            ((m == 0) ? m0_rdata : m1_rdata) !== rdata)
            post_ok = 1'b0;
        last_served = m;
    endtask

    task automatic test_reset();
        set_master(0, 1'b1, 1'b1, 4'hF, 8'hFF);
        set_master(1, 1'b1, 1'b1, 4'hE, 8'hEE);
        s_ready = 1'b1; s_rdata = 8'h77; rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({gnt, s_sel, s_we, s_addr, s_wdata} !== 15'd0) begin
            tests_failed++;
            $display("FAIL reset_slave_side: got gnt=%b sel=%b we=%b addr=%h wdata=%h, want all 0",
                     gnt, s_sel, s_we, s_addr, s_wdata);
        end
        tests_run++;
        if ({m0_ack, m0_err, m1_ack, m1_err, m0_rdata, m1_rdata} !== 20'd0) begin
            tests_failed++;
            $display("FAIL reset_master_side: got ack=%b%b err=%b%b rdata=%h/%h, want all 0",
                     m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata);
        end
        m1_req = 1'b0; s_ready = 1'b0; rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (gnt !== 2'b01 || s_addr !== 4'hF) begin
            tests_failed++;
            $display("FAIL reset_first_grant: got gnt=%b addr=%h, want 01/f", gnt, s_addr);
        end
        s_ready = 1'b1;
        @(negedge clk);
        s_ready = 1'b0; m0_req = 1'b0;
        tests_run++;
        if (m0_ack !== 1'b1 || m0_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_first_ack: got ack=%b err=%b, want 1/0", m0_ack, m0_err);
        end
        @(negedge clk);
        last_served = 0;
    endtask

    task automatic test_write_m0();
        int at; logic e; logic [7:0] rdv; bit h, p;
        run_txn(0, 1'b1, 4'h1, 8'hA5, 2, 8'h5A, at, e, rdv, h, p);
        tests_run++;
        if (!h || !p || at != 4 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_m0: got hold=%0d pulse=%0d ack_at=%0d err=%b, want 1/1/4/0",
                     h, p, at, e);
        end
    endtask

    task automatic test_read_m1();
        int at; logic e; logic [7:0] rdv; bit h, p;
        run_txn(1, 1'b0, 4'h3, 8'h00, 0, 8'h3C, at, e, rdv, h, p);
        tests_run++;
        if (!h || !p || at != 2 || e !== 1'b0 || rdv !== 8'h3C) begin
            tests_failed++;
            $display("FAIL read_m1: got hold=%0d pulse=%0d ack_at=%0d err=%b rdata=%h, want 1/1/2/0/3c",
                     h, p, at, e, rdv);
        end
    endtask

    task automatic test_timeout();
        int at; logic e; logic [7:0] rdv; bit h, p;
        run_txn(0, 1'b0, 4'h7, 8'h00, 1000, 8'h00, at, e, rdv, h, p);
        tests_run++;
        if (!h || !p || at != TIMEOUT + 1 || e !== 1'b1 || rdv !== 8'hFF) begin
            tests_failed++;
            $display("FAIL timeout_abort: got hold=%0d pulse=%0d ack_at=%0d err=%b rdata=%h, want 1/1/%0d/1/ff",
                     h, p, at, e, rdv, TIMEOUT + 1);
        end
        run_txn(0, 1'b0, 4'h7, 8'h00, TIMEOUT - 1, 8'h42, at, e, rdv, h, p);
        tests_run++;
        if (!h || !p || at != TIMEOUT + 1 || e !== 1'b0 || rdv !== 8'h42) begin
            tests_failed++;
            $display("FAIL timeout_ready_at_limit: got hold=%0d pulse=%0d ack_at=%0d err=%b rdata=%h, want 1/1/%0d/0/42",
                     h, p, at, e, rdv, TIMEOUT + 1);
        end
    endtask

    task automatic test_back_to_back();
        int owners[$];
        int acks[$];
        bit bad = 1'b0;
        logic [1:0] prev = 2'b00;
        do_reset();
        m0_req = 1'b1; m1_req = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (gnt == 2'b11 || (m0_ack && m1_ack)) bad = 1'b1;
            if (prev == 2'b00 && gnt != 2'b00) owners.push_back(gnt == 2'b10 ? 1 : 0);
            if (m0_ack) acks.push_back(0);
            if (m1_ack) acks.push_back(1);
            prev = gnt;
            s_ready = s_sel;
        end
        m0_req = 1'b0; m1_req = 1'b0; s_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bad || owners.size() != 8 || acks.size() != 8) begin
            tests_failed++;
            $display("FAIL b2b_counts: got overlap=%0d grants=%0d acks=%0d, want 0/8/8",
                     bad, owners.size(), acks.size());
        end
        for (int i = 0; i < owners.size() && i < acks.size(); i++) begin
            tests_run++;
            if (owners[i] != i % 2 || acks[i] != i % 2) begin
                tests_failed++;
                $display("FAIL b2b_order[%0d]: got grant m%0d ack m%0d, want m%0d",
                         i, owners[i], acks[i], i % 2);
            end
        end
        last_served = 1;
    endtask

    task automatic test_reset_mid_bus();
        m1_req = 1'b1; m1_addr = 4'h9;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (gnt !== 2'b10) begin
            tests_failed++;
            $display("FAIL rst_mid_setup: got gnt=%b, want 10", gnt);
        end
        rst = 1'b1; s_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({gnt, s_sel, s_we, s_addr, s_wdata, m0_ack, m0_err, m1_ack, m1_err, m0_rdata, m1_rdata} !== 35'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_values: got gnt=%b sel=%b addr=%h ack=%b%b rdata=%h/%h, want all 0",
                     gnt, s_sel, s_addr, m0_ack, m1_ack, m0_rdata, m1_rdata);
        end
        s_ready = 1'b0; rst = 1'b0;
        m0_req = 1'b1;
        @(negedge clk);
        tests_run++;
        if (m1_ack !== 1'b0 || gnt !== 2'b01) begin
            tests_failed++;
            $display("FAIL rst_mid_tie: got m1_ack=%b gnt=%b, want 0/01", m1_ack, gnt);
        end
        s_ready = 1'b1;
        @(negedge clk);
        m0_req = 1'b0; s_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (gnt !== 2'b10) begin
            tests_failed++;
            $display("FAIL rst_mid_second: got gnt=%b, want 10", gnt);
        end
        s_ready = 1'b1;
        @(negedge clk);
        m1_req = 1'b0; s_ready = 1'b0;
        @(negedge clk);
        last_served = 1;
    endtask

    task automatic test_idle_ready();
        bit bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            s_ready = 1'($urandom);
            s_rdata = 8'($urandom);
            @(negedge clk);
            if (m0_ack || m1_ack || s_sel || gnt != 2'b00) bad = 1'b1;
        end
        s_ready = 1'b0;
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL idle_ready: got spurious ack or select, want none");
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 30; it++) begin
            int mode = int'($urandom_range(0, 2));
            if (mode < 2) begin
                int at, lat; logic e; logic [7:0] rdv, rd; bit h, p;
                logic we = 1'($urandom);
                bit exp_err;
                lat = int'($urandom_range(0, TIMEOUT + 1));
                rd  = 8'($urandom);
                exp_err = (lat >= TIMEOUT);
                run_txn(mode, we, 4'($urandom), 8'($urandom), lat, rd, at, e, rdv, h, p);
                tests_run++;
                if (!h || !p || at != (exp_err ? TIMEOUT + 1 : lat + 2) || e !== exp_err ||
                    (exp_err && rdv !== 8'hFF) || (!exp_err && !we && rdv !== rd)) begin
                    tests_failed++;
                    $display("FAIL rand_txn[%0d]: m%0d lat=%0d got hold=%0d pulse=%0d ack_at=%0d err=%b rdata=%h, want err=%0d rdata=%h",
                             it, mode, lat, h, p, at, e, rdv, exp_err, exp_err ? 8'hFF : rd);
                end
            end else begin
                logic [3:0] a0 = 4'($urandom), a1 = 4'($urandom);
                int exp_first = (last_served == 1) ? 0 : 1;
                int order[$];
                logic [3:0] first_addr = 4'd0;
                int nacks = 0;
                logic [1:0] prev = 2'b00;
                set_master(0, 1'b1, 1'b0, a0, 8'($urandom));
                set_master(1, 1'b1, 1'b0, a1, 8'($urandom));
                for (int c = 0; c < 12 && nacks < 2; c++) begin
                    @(negedge clk);
                    if (prev == 2'b00 && gnt != 2'b00) begin
                        if (order.size() == 0) first_addr = s_addr;
                        order.push_back(gnt == 2'b10 ? 1 : 0);
                    end
                    if (m0_ack) begin m0_req = 1'b0; nacks++; end
                    if (m1_ack) begin m1_req = 1'b0; nacks++; end
                    prev = gnt;
                    s_ready = s_sel;
                end
                m0_req = 1'b0; m1_req = 1'b0; s_ready = 1'b0;
                @(negedge clk);
                tests_run++;
                if (order.size() != 2 || nacks != 2 || order[0] != exp_first ||
                    order[1] != 1 - exp_first || first_addr !== (exp_first == 0 ? a0 : a1)) begin
                    tests_failed++;
                    $display("FAIL rand_tie[%0d]: got grants=%0d acks=%0d first=m%0d addr=%h, want 2/2 first=m%0d addr=%h",
                             it, order.size(), nacks, order.size() > 0 ? order[0] : -1,
                             first_addr, exp_first, exp_first == 0 ? a0 : a1);
                end
                last_served = 1 - exp_first;
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_m0();
        test_read_m1();
        test_timeout();
        test_idle_ready();
        test_back_to_back();
        test_reset_mid_bus();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
